// File: rtl/ff_pkg.sv
// ff_pkg: shared constants and helpers for the d_t_ff storage cell.
//   FF_TYPE_DFF / FF_TYPE_TFF : legal cell-type strings (3 chars, packed)
//   ff_type_valid()           : true when a cell-type string is legal
package ff_pkg;
  localparam int FF_TYPE_W = 24;  // three 8-bit characters
  typedef logic [FF_TYPE_W-1:0] ff_type_t;

  localparam ff_type_t FF_TYPE_DFF = "DFF";
  localparam ff_type_t FF_TYPE_TFF = "TFF";

  function automatic logic ff_type_valid(input ff_type_t t);
    return (t == FF_TYPE_DFF) || (t == FF_TYPE_TFF);
  endfunction
endpackage

// File: rtl/d_t_ff_if.sv
// d_t_ff_if: data bundle of the d_t_ff cell.
//   d    : data (DFF) or per-bit toggle enable (TFF), driven by the master
//   q    : registered state, driven by the cell
//   qbar : ~q, driven by the cell
interface d_t_ff_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (output d, input q, input qbar);
  modport slave  (input d, output q, output qbar);
endinterface

// File: rtl/dff_cell.sv
// dff_cell: plain WIDTH-bit D register with async active-high reset.
//   clk  : rising-edge clock
//   rst  : async reset, loads RESET_VALUE
//   d    : next state
//   q    : registered state
//   qbar : ~q, combinational from the register so it can never disagree
module dff_cell #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "dff_cell: WIDTH must be 1..64");
  end

  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] state_q;

  always_comb state_d = d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RESET_VALUE;
    else     state_q <= state_d;
  end

  assign q    = state_q;
  assign qbar = ~state_q;
endmodule

// File: rtl/d_t_ff.sv
// d_t_ff: WIDTH-bit storage cell, D or T flavour chosen by FF_TYPE.
//   clk : rising-edge clock
//   rst : async active-high reset, loads RESET_VALUE
//   ff  : slave side of d_t_ff_if (d in, q/qbar out)
// DFF: q <= d.  TFF: q <= q ^ d.  Both reuse one dff_cell; only the
// next-state mux differs, so DFF mode is the bare dff_cell.
module d_t_ff
  import ff_pkg::*;
#(
  parameter ff_type_t         FF_TYPE     = FF_TYPE_DFF,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic      clk,
  input logic      rst,
  d_t_ff_if.slave  ff
);
  if (!ff_type_valid(FF_TYPE)) begin : g_bad_type
    $fatal(1, "d_t_ff: FF_TYPE must be \"DFF\" or \"TFF\"");
  end

  logic [WIDTH-1:0] cell_d;
  logic [WIDTH-1:0] cell_q;
  logic [WIDTH-1:0] cell_qbar;

  if (FF_TYPE == FF_TYPE_TFF) begin : g_tff
    // X on d propagates into q through the xor; no masking wanted
    always_comb cell_d = cell_q ^ ff.d;
  end else begin : g_dff
    always_comb cell_d = ff.d;
  end

  dff_cell #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_cell (
    .clk  (clk),
    .rst  (rst),
    .d    (cell_d),
    .q    (cell_q),
    .qbar (cell_qbar)
  );

  assign ff.q    = cell_q;
  assign ff.qbar = cell_qbar;
endmodule

// File: tb/tb_d_t_ff.sv
// tb_d_t_ff: checks d_t_ff in DFF, TFF and multi-bit TFF configurations,
// plus DFF-mode equivalence against a standalone dff_cell.
module tb_d_t_ff;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  d_t_ff_if #(.WIDTH(1)) if_dff  ();
  d_t_ff_if #(.WIDTH(1)) if_tff  ();
  d_t_ff_if #(.WIDTH(4)) if_tff4 ();
  d_t_ff_if #(.WIDTH(8)) if_eq   ();

  logic [7:0] cell_q;
  logic [7:0] cell_qbar;

  d_t_ff #(.FF_TYPE("DFF"), .WIDTH(1)) u_dff (.clk(clk), .rst(rst), .ff(if_dff.slave));
  d_t_ff #(.FF_TYPE("TFF"), .WIDTH(1)) u_tff (.clk(clk), .rst(rst), .ff(if_tff.slave));
  d_t_ff #(.FF_TYPE("TFF"), .WIDTH(4), .RESET_VALUE(4'b1010)) u_tff4 (
    .clk(clk), .rst(rst), .ff(if_tff4.slave));
  d_t_ff #(.FF_TYPE("DFF"), .WIDTH(8)) u_eq (.clk(clk), .rst(rst), .ff(if_eq.slave));
  dff_cell #(.WIDTH(8)) u_ref (
    .clk(clk), .rst(rst), .d(if_eq.d), .q(cell_q), .qbar(cell_qbar));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // brief reset pulse between a negedge and the following posedge
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if_dff.d = 1'b1; if_tff.d = 1'b1; if_tff4.d = 4'hF;
    #2 rst = 1'b1;
    #1;  // still before the next rising edge
    n_tests++;
    if (if_dff.q !== 1'b0 || if_dff.qbar !== 1'b1) begin
      n_fail++; $display("FAIL rst_async_dff: q=%b qbar=%b want q=0 qbar=1", if_dff.q, if_dff.qbar);
    end
    n_tests++;
    if (if_tff.q !== 1'b0 || if_tff.qbar !== 1'b1) begin
      n_fail++; $display("FAIL rst_async_tff: q=%b qbar=%b want q=0 qbar=1", if_tff.q, if_tff.qbar);
    end
    n_tests++;
    if (if_tff4.q !== 4'b1010 || if_tff4.qbar !== 4'b0101) begin
      n_fail++; $display("FAIL rst_async_tff4: q=%b qbar=%b want q=1010 qbar=0101", if_tff4.q, if_tff4.qbar);
    end
    // clock edge while reset held must not disturb anything
    @(posedge clk); #1;
    n_tests++;
    if (if_dff.q !== 1'b0 || if_tff.q !== 1'b0 || if_tff4.q !== 4'b1010) begin
      n_fail++; $display("FAIL rst_hold: dff=%b tff=%b tff4=%b want 0 0 1010", if_dff.q, if_tff.q, if_tff4.q);
    end
    @(negedge clk);
    rst = 1'b0;
    if_dff.d = 1'b1; if_tff.d = 1'b0; if_tff4.d = 4'h0;
    @(posedge clk); #1;
    n_tests++;
    if (if_dff.q !== 1'b1 || if_dff.qbar !== 1'b0) begin
      n_fail++; $display("FAIL rst_release_dff: q=%b qbar=%b want q=1 qbar=0", if_dff.q, if_dff.qbar);
    end
    n_tests++;
    if (if_tff.q !== 1'b0 || if_tff4.q !== 4'b1010) begin
      n_fail++; $display("FAIL rst_release_tff: tff=%b tff4=%b want 0 1010", if_tff.q, if_tff4.q);
    end
  endtask

  task automatic test_dff_seq();
    logic sb[$];
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_dff.d = pat[i];
      sb.push_back(pat[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (if_dff.q !== e || if_dff.qbar !== ~e) begin
        n_fail++;
        $display("FAIL dff_seq[%0d]: q=%b qbar=%b want q=%b qbar=%b", i, if_dff.q, if_dff.qbar, e, ~e);
      end
    end
  endtask

  task automatic test_tff_toggle();
    logic sb[$];
    logic m;
    logic e;
    pulse_reset();
    m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if_tff.d = (i < 4);
      m = m ^ (i < 4);
      sb.push_back(m);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (if_tff.q !== e || if_tff.qbar !== ~e) begin
        n_fail++;
        $display("FAIL tff_toggle[%0d]: q=%b qbar=%b want q=%b qbar=%b", i, if_tff.q, if_tff.qbar, e, ~e);
      end
    end
  endtask

  task automatic test_multibit_tff();
    logic [3:0] sb[$];
    logic [3:0] m;
    logic [3:0] v;
    logic [3:0] e;
    pulse_reset();
    m = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v = (i == 0) ? 4'b0011 : 4'($urandom);
      if_tff4.d = v;
      m = m ^ v;
      sb.push_back(m);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (if_tff4.q !== e || if_tff4.qbar !== ~e) begin
        n_fail++;
        $display("FAIL tff4[%0d]: q=%b qbar=%b want q=%b qbar=%b", i, if_tff4.q, if_tff4.qbar, e, ~e);
      end
    end
    if_tff4.d = 4'h0;
  endtask

  task automatic test_equivalence();
    logic [7:0] sb[$];
    logic [7:0] exp_q;
    logic [7:0] v;
    if_eq.d = 8'h00;
    pulse_reset();
    exp_q = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      @(clk);
      #1;
      if (clk && sb.size() > 0) exp_q = sb.pop_front();
      n_tests++;
      if (if_eq.q !== cell_q || if_eq.qbar !== cell_qbar) begin
        n_fail++;
        $display("FAIL equiv[%0d]: dut q=%h qbar=%h ref q=%h qbar=%h", i, if_eq.q, if_eq.qbar, cell_q, cell_qbar);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "equivalence lost");
      end
      n_tests++;
      if (if_eq.q !== exp_q || if_eq.qbar !== ~exp_q) begin
        n_fail++;
        $display("FAIL equiv_model[%0d]: q=%h qbar=%h want q=%h qbar=%h", i, if_eq.q, if_eq.qbar, exp_q, ~exp_q);
      end
      #1;
      v = 8'($urandom);
      if_eq.d = v;
      // only values driven in the low phase survive to the next rising edge
      if (!clk) sb.push_back(v);
    end
  endtask

  task automatic test_reset_priority();
    if_tff.d = 1'b0; if_tff4.d = 4'h0;
    pulse_reset();
    @(negedge clk);
    if_tff.d = 1'b1; if_tff4.d = 4'hF;
    #5 rst = 1'b1;  // lands on the rising edge
    #1;
    n_tests++;
    if (if_tff.q !== 1'b0 || if_tff.qbar !== 1'b1 || if_tff4.q !== 4'b1010) begin
      n_fail++;
      $display("FAIL rst_priority: tff q=%b qbar=%b tff4=%b want 0 1 1010", if_tff.q, if_tff.qbar, if_tff4.q);
    end
    // build toggle history, then reset mid-cycle
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (if_tff.q !== 1'b1) begin
      n_fail++; $display("FAIL tff_history: q=%b want 1", if_tff.q);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (if_tff.q !== 1'b0 || if_tff.qbar !== 1'b1 || if_tff4.q !== 4'b1010) begin
      n_fail++;
      $display("FAIL rst_midop: tff q=%b qbar=%b tff4=%b want 0 1 1010", if_tff.q, if_tff.qbar, if_tff4.q);
    end
    @(negedge clk);
    rst = 1'b0;
    if_tff.d = 1'b0; if_tff4.d = 4'h0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    if_dff.d = 1'b0; if_tff.d = 1'b0; if_tff4.d = 4'h0; if_eq.d = 8'h00;
    test_reset();
    test_dff_seq();
    test_tff_toggle();
    test_multibit_tff();
    test_equivalence();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
